// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared FSM state encoding and frame-length helpers
// for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  // Serializer states, 3-bit encoding
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Cycles per frame: start + data + optional parity + stop
  function automatic int frame_len(input int data_width, input bit parity_en);
    return data_width + (parity_en ? 3 : 2);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read side of the async FIFO as seen from its consumer.
// master = FIFO (drives empty flag and head word), slave = consumer (pops).
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  r_inc;

  modport master (output r_empty, output RD_DATA, input r_inc);
  modport slave  (input r_empty, input RD_DATA, output r_inc);
endinterface

// File: rtl/tx_parity_calc.sv
// tx_parity_calc: combinational parity of a data word.
// par_typ = 0 gives even parity, 1 gives odd parity.
// Only present when FIFO_UART_TX_PARITY_EN is defined.
`ifdef FIFO_UART_TX_PARITY_EN
module tx_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);
  assign par_bit = (^data) ^ par_typ;
endmodule
`endif

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from the async FIFO read port and sends each as
// a UART frame (start, data LSB-first, optional parity, stop), one bit per
// CLK. Frames run back-to-back while the FIFO holds data.
// Optional parity bit and PAR_TYP port: define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  fifo_uart_tx_if.slave     fifo,
`ifdef FIFO_UART_TX_PARITY_EN
  input  logic              PAR_TYP,
`endif
  output logic              TX_OUT,
  output logic              busy
);

`ifdef FIFO_UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_LEN = frame_len(DATA_WIDTH, PAR_EN);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  r_inc_q, r_inc_d;

`ifdef FIFO_UART_TX_PARITY_EN
  // Parity is latched with the word so later RD_DATA changes cannot affect it
  logic par_q, par_d, par_calc;

  tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (fifo.RD_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );
`endif

  // Next-state logic: capture in IDLE/STOP, then shift out the frame
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    r_inc_d = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE, STOP: begin
        if (!fifo.r_empty) begin
          shift_d = fifo.RD_DATA;
          r_inc_d = 1'b1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
`ifdef FIFO_UART_TX_PARITY_EN
          par_d   = par_calc;
`endif
        end else begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      START: begin
        tx_d    = shift_q[0];
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          tx_d    = par_q;
          state_d = PARITY;
`else
          tx_d    = 1'b1;
          state_d = STOP;
`endif
        end else begin
          tx_d  = shift_d[0];
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx_d    = 1'b1;
        state_d = STOP;
      end
`endif
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      r_inc_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      r_inc_q <= r_inc_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign TX_OUT     = tx_q;
  assign busy       = busy_q;
  assign fifo.r_inc = r_inc_q;

endmodule
